// File: rtl/fifo_ram_ctrl.sv
// Show-ahead FIFO controller driving an external simple dual-port RAM with
// 1-cycle registered read latency; a 2-entry prefetch (output + skid) hides it.
module fifo_ram_ctrl #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned AWIDTH = 3,
   parameter int unsigned AFULL  = 6,
   parameter int unsigned AEMPTY = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wrreq_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              rdreq_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              ram_wr_en_o,
   output logic [AWIDTH-1:0] ram_wr_addr_o,
   output logic [DWIDTH-1:0] ram_wr_data_o,
   output logic              ram_rd_en_o,
   output logic [AWIDTH-1:0] ram_rd_addr_o,
   input  logic [DWIDTH-1:0] ram_rd_data_i
);

   localparam int unsigned DEPTH = 1 << AWIDTH;
   localparam int unsigned CW    = AWIDTH + 1;

   logic [AWIDTH-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]     ram_cnt, usedw_q;
   logic [CW-1:0]     ram_cnt_n, usedw_n;
   logic              out_v, skid_v, inflight;
   logic              out_v_n, skid_v_n;
   logic [DWIDTH-1:0] q_q, skid_q, q_n, skid_n;
   logic              wr_acc, rd_acc, fetch;
   logic [1:0]        occ_after;

   // Accepts use registered flags; reset blocks any RAM access in its cycle.
   assign wr_acc    = wrreq_i & ~full_o & ~srst_i;
   assign rd_acc    = rdreq_i & out_v;
   assign occ_after = 2'(out_v) + 2'(skid_v) + 2'(inflight) - 2'(rd_acc);
   assign fetch     = (ram_cnt != '0) && (occ_after < 2'd2) && !srst_i;

   assign ram_wr_en_o   = wr_acc;
   assign ram_wr_addr_o = wr_ptr;
   assign ram_wr_data_o = data_i;
   assign ram_rd_en_o   = fetch;
   assign ram_rd_addr_o = rd_ptr;

   assign q_o     = q_q;
   assign empty_o = ~out_v;
   assign usedw_o = usedw_q;

   assign ram_cnt_n = ram_cnt + CW'(wr_acc) - CW'(fetch);
   assign usedw_n   = usedw_q + CW'(wr_acc) - CW'(rd_acc);

   // Prefetch buffer: landing word goes to the output register when it is
   // free (or being popped) and the skid is empty, otherwise to the skid.
   always_comb begin
      out_v_n  = out_v;
      skid_v_n = skid_v;
      q_n      = q_q;
      skid_n   = skid_q;
      if (rd_acc) begin
         if (skid_v) begin
            q_n = skid_q;
            if (inflight) skid_n = ram_rd_data_i;
            else          skid_v_n = 1'b0;
         end else if (inflight) begin
            q_n = ram_rd_data_i;
         end else begin
            out_v_n = 1'b0;
         end
      end else if (inflight) begin
         if (!out_v) begin
            q_n     = ram_rd_data_i;
            out_v_n = 1'b1;
         end else begin
            skid_n   = ram_rd_data_i;
            skid_v_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         ram_cnt        <= '0;
         usedw_q        <= '0;
         out_v          <= 1'b0;
         skid_v         <= 1'b0;
         inflight       <= 1'b0;
         q_q            <= '0;
         skid_q         <= '0;
         full_o         <= 1'b0;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AWIDTH'(1);
         if (fetch)  rd_ptr <= rd_ptr + AWIDTH'(1);
         ram_cnt        <= ram_cnt_n;
         usedw_q        <= usedw_n;
         out_v          <= out_v_n;
         skid_v         <= skid_v_n;
         inflight       <= fetch;
         q_q            <= q_n;
         skid_q         <= skid_n;
         full_o         <= (usedw_n == CW'(DEPTH));
         almost_full_o  <= (usedw_n >= CW'(AFULL));
         almost_empty_o <= (usedw_n <  CW'(AEMPTY));
      end
   end

endmodule
